systolic_ctrl: RTL and testbench

Sequencer for the 8x8 systolic MAC array. On `start` it clears the accumulators, streams K activation and weight vectors from the operand buffers, applies the diagonal input skew, and drives the array's global, per-row and per-column enables. It then drains the pipeline and pulses `done`. It sits between the operand buffers (SRAMs with 1-cycle read latency) and the array.

---
 rtl/systolic_pkg.sv | 33 +++
 rtl/systolic_ctrl_skew_line.sv | 50 +++++
 rtl/systolic_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_systolic_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// ----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the 8x8 systolic MAC array sequencer:
//   - state_t       : sequencer FSM states
//   - *_DEF         : default array / operand / buffer dimensions
//   - drain_steps() : number of steps needed to flush the array after the
//                     last operand read (read latency + skew + propagation
//                     + MAC pipeline)
// ----------------------------------------------------------------------------
package systolic_pkg;

    localparam int N_DEF       = 8;
    localparam int A_W_DEF     = 8;
    localparam int W_W_DEF     = 8;
    localparam int K_MAX_DEF   = 256;
    localparam int ADDR_W_DEF  = 8;
    localparam int MAC_LAT_DEF = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // One step of buffer read latency, (n-1) steps of input skew, (n-1) steps
    // of propagation across the array, then the MAC pipeline itself.
    function automatic int drain_steps(input int n, input int mac_lat);
        return 1 + 2 * (n - 1) + mac_lat;
    endfunction

endpackage

// File: rtl/systolic_ctrl_skew_line.sv
// ----------------------------------------------------------------------------
// skew_line
// Delay line of DEPTH registers that advances only on `step`. DEPTH = 0 is a
// plain wire. Used to build the diagonal input skew of the systolic array.
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-low reset (clears all stages)
//   step  in   shift enable
//   din   in   WIDTH-bit input sample
//   dout  out  din delayed by DEPTH steps
// ----------------------------------------------------------------------------
module skew_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            // clk/rst/step have no function without storage.
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, rst, step};
            assign dout = din;
        end else begin : g_regs
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= '0;
                    end
                end else if (step) begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_ctrl.sv
// ----------------------------------------------------------------------------
// systolic_ctrl
// Sequencer for an NxN systolic MAC array. On `start` it clears the
// accumulators, streams cfg_k activation/weight vectors out of the operand
// buffers (1-cycle read latency), skews them diagonally into the array,
// drives global/per-row/per-column enables, drains the pipeline and pulses
// `done`. buf_ready=0 freezes all progress (no read, no shift, arr_en=0).
//
// Optional feature: define SYSTOLIC_CTRL_PERF_EN to add perf_active_cycles
// and perf_stall_cycles (32-bit, saturating, cleared on start acceptance).
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   start                    begin tile (only accepted in IDLE)
//   cfg_k/cfg_rows/cfg_cols  tile shape, latched (and clamped) at start
//   buf_ready                operand buffers can serve; low = stall
//   busy, done               tile in progress; 1-cycle completion pulse
//   act_rd_*, wgt_rd_*       operand buffer read ports
//   arr_clr, arr_en          accumulator clear, global enable
//   arr_row_en, arr_col_en   active row/column masks
//   arr_act, arr_wgt         skewed operands into column 0 / row 0
// ----------------------------------------------------------------------------
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int A_W     = A_W_DEF,
    parameter int W_W     = W_W_DEF,
    parameter int K_MAX   = K_MAX_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int MAC_LAT = MAC_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   cfg_k,
    input  logic [3:0]        cfg_rows,
    input  logic [3:0]        cfg_cols,
    input  logic              buf_ready,
    output logic              busy,
    output logic              done,
    output logic              act_rd_en,
    output logic [ADDR_W-1:0] act_rd_addr,
    input  logic [N*A_W-1:0]  act_rd_data,
    output logic              wgt_rd_en,
    output logic [ADDR_W-1:0] wgt_rd_addr,
    input  logic [N*W_W-1:0]  wgt_rd_data,
    output logic              arr_clr,
    output logic              arr_en,
    output logic [N-1:0]      arr_row_en,
    output logic [N-1:0]      arr_col_en,
    output logic [N*A_W-1:0]  arr_act,
    output logic [N*W_W-1:0]  arr_wgt
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_active_cycles,
    output logic [31:0]       perf_stall_cycles
`endif
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(drain_steps(N, MAC_LAT) - 1);

    function automatic logic [3:0] clamp_dim(input logic [3:0] v);
        if (v == 4'd0)      return 4'd1;
        if (v > 4'(N))      return 4'(N);
        return v;
    endfunction

    function automatic logic [CNT_W-1:0] clamp_k(input logic [CNT_W-1:0] v);
        if (v > CNT_W'(K_MAX)) return CNT_W'(K_MAX);
        return v;
    endfunction

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;      // k index in FEED, step index in DRAIN
    logic [CNT_W-1:0] k_q;
    logic [3:0]       rows_q, cols_q;
    logic             vld;      // buffer read data is valid this step
    logic             step;
    logic             accept;
    logic             feed_last, drain_last;
    logic [N-1:0]     row_mask, col_mask;

    assign step       = ((state == FEED) || (state == DRAIN)) && buf_ready;
    assign accept     = (state == IDLE) && start;
    assign feed_last  = (cnt == k_q - CNT_ONE);
    assign drain_last = (cnt == DRAIN_LAST);

    // ---- FSM state and tile counters ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            k_q    <= '0;
            rows_q <= '0;
            cols_q <= '0;
            vld    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                k_q    <= clamp_k(cfg_k);
                rows_q <= clamp_dim(cfg_rows);
                cols_q <= clamp_dim(cfg_cols);
                cnt    <= '0;
            end else if (step) begin
                if (state == FEED) begin
                    cnt <= feed_last ? '0 : cnt + CNT_ONE;
                end else begin
                    cnt <= drain_last ? '0 : cnt + CNT_ONE;
                end
                // A read issued on this step returns data for the next one.
                vld <= (state == FEED);
            end
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        arr_clr   = 1'b0;
        arr_en    = step;
        act_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = CLEAR;
            end
            CLEAR: begin
                arr_clr  = 1'b1;
                arr_en   = 1'b1;
                state_nx = (k_q == '0) ? DRAIN : FEED;
            end
            FEED: begin
                act_rd_en = buf_ready;
                if (step && feed_last) state_nx = DRAIN;
            end
            DRAIN: begin
                if (step && drain_last) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign wgt_rd_en   = act_rd_en;
    assign act_rd_addr = (state == FEED) ? cnt[ADDR_W-1:0] : '0;
    assign wgt_rd_addr = act_rd_addr;

    always_comb begin
        row_mask   = '0;
        col_mask   = '0;
        arr_row_en = '0;
        arr_col_en = '0;
        for (int i = 0; i < N; i++) begin
            row_mask[i] = (4'(i) < rows_q);
            col_mask[i] = (4'(i) < cols_q);
        end
        if (busy) begin
            arr_row_en = row_mask;
            arr_col_en = col_mask;
        end
    end

    // ---- Diagonal input skew: lane i delayed by i steps ----
    for (genvar r = 0; r < N; r++) begin : g_act
        logic [A_W-1:0] din;
        assign din = (vld && row_mask[r]) ? act_rd_data[r*A_W +: A_W] : '0;
        skew_line #(.WIDTH(A_W), .DEPTH(r)) u_skew (
            .clk  (clk),
            .rst  (rst),
            .step (step),
            .din  (din),
            .dout (arr_act[r*A_W +: A_W])
        );
    end

    for (genvar c = 0; c < N; c++) begin : g_wgt
        logic [W_W-1:0] din;
        assign din = (vld && col_mask[c]) ? wgt_rd_data[c*W_W +: W_W] : '0;
        skew_line #(.WIDTH(W_W), .DEPTH(c)) u_skew (
            .clk  (clk),
            .rst  (rst),
            .step (step),
            .din  (din),
            .dout (arr_wgt[c*W_W +: W_W])
        );
    end

`ifdef SYSTOLIC_CTRL_PERF_EN
    // ---- Saturating performance counters ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_active_cycles <= '0;
            perf_stall_cycles  <= '0;
        end else if (accept) begin
            perf_active_cycles <= '0;
            perf_stall_cycles  <= '0;
        end else begin
            if (step && (perf_active_cycles != '1)) begin
                perf_active_cycles <= perf_active_cycles + 32'd1;
            end
            if (busy && !buf_ready && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// ----------------------------------------------------------------------------
// tb_systolic_ctrl
// Self-checking bench for systolic_ctrl. Operand buffers are modelled as
// 1-cycle-latency SRAMs. Expected read addresses and per-step skewed operand
// vectors are queued when a tile is launched and popped as the DUT steps.
// ----------------------------------------------------------------------------
module tb_systolic_ctrl;
    import systolic_pkg::*;

    localparam int N      = 8;
    localparam int A_W    = 8;
    localparam int W_W    = 8;
    localparam int ADDR_W = 8;
    localparam int DRAIN  = 1 + 2 * (N - 1) + 1;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   cfg_k;
    logic [3:0]        cfg_rows;
    logic [3:0]        cfg_cols;
    logic              buf_ready;
    logic              busy;
    logic              done;
    logic              act_rd_en;
    logic [ADDR_W-1:0] act_rd_addr;
    logic [N*A_W-1:0]  act_rd_data;
    logic              wgt_rd_en;
    logic [ADDR_W-1:0] wgt_rd_addr;
    logic [N*W_W-1:0]  wgt_rd_data;
    logic              arr_clr;
    logic              arr_en;
    logic [N-1:0]      arr_row_en;
    logic [N-1:0]      arr_col_en;
    logic [N*A_W-1:0]  arr_act;
    logic [N*W_W-1:0]  arr_wgt;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0]       perf_active_cycles;
    logic [31:0]       perf_stall_cycles;
`endif

    systolic_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_k       (cfg_k),
        .cfg_rows    (cfg_rows),
        .cfg_cols    (cfg_cols),
        .buf_ready   (buf_ready),
        .busy        (busy),
        .done        (done),
        .act_rd_en   (act_rd_en),
        .act_rd_addr (act_rd_addr),
        .act_rd_data (act_rd_data),
        .wgt_rd_en   (wgt_rd_en),
        .wgt_rd_addr (wgt_rd_addr),
        .wgt_rd_data (wgt_rd_data),
        .arr_clr     (arr_clr),
        .arr_en      (arr_en),
        .arr_row_en  (arr_row_en),
        .arr_col_en  (arr_col_en),
        .arr_act     (arr_act),
        .arr_wgt     (arr_wgt)
`ifdef SYSTOLIC_CTRL_PERF_EN
        ,
        .perf_active_cycles (perf_active_cycles),
        .perf_stall_cycles  (perf_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [A_W-1:0] act_mem [256][N];
    logic [W_W-1:0] wgt_mem [256][N];

    // 1-cycle read latency buffers; output holds between reads.
    always @(posedge clk) begin
        if (act_rd_en) begin
            for (int r = 0; r < N; r++) act_rd_data[r*A_W +: A_W] <= act_mem[act_rd_addr][r];
        end
        if (wgt_rd_en) begin
            for (int c = 0; c < N; c++) wgt_rd_data[c*W_W +: W_W] <= wgt_mem[wgt_rd_addr][c];
        end
    end

    int errors = 0;
    int checks = 0;

    int               addr_q[$];
    logic [N*A_W-1:0] act_q[$];
    logic [N*W_W-1:0] wgt_q[$];

    task automatic fill_mem(input int mode);
        for (int k = 0; k < 256; k++) begin
            for (int i = 0; i < N; i++) begin
                if (mode == 0) begin
                    act_mem[k][i] = 8'(k + 1);
                    wgt_mem[k][i] = 8'd1;
                end else begin
                    act_mem[k][i] = 8'(k * 8 + i + 1);
                    wgt_mem[k][i] = 8'(k * 3 + i * 17 + 7);
                end
            end
        end
    endtask

    // Launches one tile and follows it to done. Returns the start-to-done
    // latency in cycles (-1 on timeout) and the number of reads issued.
    task automatic run_tile(input int k, input int rows, input int cols,
                            input int stall_after, input int stall_len,
                            input int pulse_at, output int lat, output int n_rd);
        int kc, rc, cc, p, stall_left, kk, ea_addr;
        logic [N-1:0]     rmask, cmask;
        logic [N*A_W-1:0] ea, ga;
        logic [N*W_W-1:0] ew, gw;
        kc = (k > 256) ? 256 : k;
        rc = (rows == 0) ? 1 : ((rows > N) ? N : rows);
        cc = (cols == 0) ? 1 : ((cols > N) ? N : cols);
        for (int i = 0; i < N; i++) begin
            rmask[i] = (i < rc);
            cmask[i] = (i < cc);
        end
        addr_q.delete();
        act_q.delete();
        wgt_q.delete();
        for (int i = 0; i < kc; i++) addr_q.push_back(i);
        // Step j: lane i carries operand k = j-1-i (1 step read latency, i steps skew).
        for (int j = 0; j < kc + DRAIN; j++) begin
            for (int i = 0; i < N; i++) begin
                kk = j - 1 - i;
                ea[i*A_W +: A_W] = (i < rc && kk >= 0 && kk < kc) ? act_mem[kk][i] : '0;
                ew[i*W_W +: W_W] = (i < cc && kk >= 0 && kk < kc) ? wgt_mem[kk][i] : '0;
            end
            act_q.push_back(ea);
            wgt_q.push_back(ew);
        end

        @(negedge clk);
        cfg_k     = 9'(k);
        cfg_rows  = 4'(rows);
        cfg_cols  = 4'(cols);
        buf_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        lat = -1;
        n_rd = 0;
        stall_left = stall_len;
        for (p = 1; p <= 400; p++) begin
            @(negedge clk);
            checks++;
            if (arr_row_en !== rmask || arr_col_en !== cmask || busy !== 1'b1) begin
                errors++;
                $display("FAIL enables cyc %0d: row=%b col=%b busy=%b expected row=%b col=%b busy=1",
                         p, arr_row_en, arr_col_en, busy, rmask, cmask);
            end
            if (p == 1) begin
                checks++;
                if (arr_clr !== 1'b1 || arr_en !== 1'b1) begin
                    errors++;
                    $display("FAIL clear_cycle: clr=%b en=%b expected 1 1", arr_clr, arr_en);
                end
            end
            if (act_rd_en) begin
                n_rd++;
                checks++;
                ea_addr = (addr_q.size() > 0) ? addr_q.pop_front() : -1;
                if (ea_addr < 0 || act_rd_addr !== 8'(ea_addr) || wgt_rd_addr !== 8'(ea_addr) || wgt_rd_en !== 1'b1) begin
                    errors++;
                    $display("FAIL rd_addr: act=%0d wgt=%0d wen=%b expected %0d", act_rd_addr, wgt_rd_addr, wgt_rd_en, ea_addr);
                end
            end
            if (!buf_ready) begin
                checks++;
                if (arr_en !== 1'b0 || act_rd_en !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_freeze: arr_en=%b rd_en=%b expected 0 0", arr_en, act_rd_en);
                end
            end else if (arr_en && !arr_clr) begin
                checks++;
                if (act_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_step: arr_en with no expected step left");
                end else begin
                    ea = act_q.pop_front();
                    ew = wgt_q.pop_front();
                    ga = arr_act;
                    gw = arr_wgt;
                    if (ga !== ea || gw !== ew) begin
                        errors++;
                        $display("FAIL skew_data cyc %0d: act=%h wgt=%h expected act=%h wgt=%h", p, ga, gw, ea, ew);
                    end
                end
            end
            if (done) begin
                lat = p;
                break;
            end
            start = (p == pulse_at);
            if (n_rd == stall_after && stall_left > 0) begin
                buf_ready = 1'b0;
                stall_left--;
            end else begin
                buf_ready = 1'b1;
            end
        end
        start = 1'b0;
        buf_ready = 1'b1;
        checks++;
        if (lat < 0) begin
            errors++;
            $display("FAIL done_timeout: no done within 400 cycles");
        end
        checks++;
        if (addr_q.size() != 0 || act_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: reads=%0d steps=%0d expected 0 0", addr_q.size(), act_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        buf_ready = 1'b1;
        cfg_k = '0;
        cfg_rows = '0;
        cfg_cols = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, act_rd_en, wgt_rd_en, arr_clr, arr_en} !== 6'b0 || act_rd_addr !== '0 ||
            wgt_rd_addr !== '0 || arr_row_en !== '0 || arr_col_en !== '0 || arr_act !== '0 || arr_wgt !== '0) begin
            errors++;
            $display("FAIL reset_values: busy=%b done=%b en=%b row=%b act=%h expected all 0", busy, done, arr_en, arr_row_en, arr_act);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || arr_row_en !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b row_en=%b expected 0 0", busy, arr_row_en);
        end
    endtask

    task automatic test_basic();
        int lat, n_rd;
        fill_mem(0);
        run_tile(4, 8, 8, -1, 0, 0, lat, n_rd);
        checks++;
        if (lat != 22 || n_rd != 4) begin
            errors++;
            $display("FAIL basic_latency: lat=%0d reads=%0d expected 22 4", lat, n_rd);
        end
    endtask

    task automatic test_stall();
        int lat, n_rd;
        fill_mem(0);
        run_tile(4, 8, 8, 2, 5, 0, lat, n_rd);
        checks++;
        if (lat != 27 || n_rd != 4) begin
            errors++;
            $display("FAIL stall_latency: lat=%0d reads=%0d expected 27 4", lat, n_rd);
        end
`ifdef SYSTOLIC_CTRL_PERF_EN
        checks++;
        if (perf_stall_cycles !== 32'd5 || perf_active_cycles !== 32'(4 + DRAIN)) begin
            errors++;
            $display("FAIL perf: active=%0d stall=%0d expected %0d 5", perf_active_cycles, perf_stall_cycles, 4 + DRAIN);
        end
`endif
    endtask

    task automatic test_partial();
        int lat, n_rd;
        fill_mem(1);
        run_tile(5, 3, 5, -1, 0, 0, lat, n_rd);
        checks++;
        if (lat != 23) begin
            errors++;
            $display("FAIL partial_latency: lat=%0d expected 23", lat);
        end
        // Out-of-range shape: rows 0 -> 1, cols 15 -> 8.
        run_tile(2, 0, 15, -1, 0, 0, lat, n_rd);
        checks++;
        if (lat != 20) begin
            errors++;
            $display("FAIL clamp_latency: lat=%0d expected 20", lat);
        end
    endtask

    task automatic test_k_zero();
        int lat, n_rd, extra_done;
        fill_mem(1);
        run_tile(0, 8, 8, -1, 0, 5, lat, n_rd);
        checks++;
        if (lat != 18 || n_rd != 0) begin
            errors++;
            $display("FAIL k0_latency: lat=%0d reads=%0d expected 18 0", lat, n_rd);
        end
        extra_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        checks++;
        if (extra_done != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_while_busy: extra_done=%0d busy=%b expected 0 0", extra_done, busy);
        end
    endtask

    task automatic test_reset_mid_tile();
        int lat, n_rd, w;
        logic seen;
        fill_mem(1);
        @(negedge clk);
        cfg_k = 9'd6;
        cfg_rows = 4'd8;
        cfg_cols = 4'd8;
        start = 1'b1;
        @(posedge clk);
        seen = 1'b0;
        for (w = 0; w < 20; w++) begin
            @(negedge clk);
            start = 1'b0;
            if (act_rd_en && act_rd_addr == 8'd2) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reach_k2: address 2 never issued");
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, act_rd_en, wgt_rd_en, arr_clr, arr_en} !== 6'b0 || act_rd_addr !== '0 ||
            arr_row_en !== '0 || arr_col_en !== '0 || arr_act !== '0 || arr_wgt !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%b rd=%b addr=%0d row=%b act=%h expected all 0",
                     busy, act_rd_en, act_rd_addr, arr_row_en, arr_act);
        end
        @(negedge clk);
        rst = 1'b1;
        run_tile(1, 8, 8, -1, 0, 0, lat, n_rd);
        checks++;
        if (lat != 19 || n_rd != 1) begin
            errors++;
            $display("FAIL restart_latency: lat=%0d reads=%0d expected 19 1", lat, n_rd);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_partial();
        test_k_zero();
        test_reset_mid_tile();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
